// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// Holds the supported opcode constants, the FSM state encoding, the ALU
// operand/operation encodings, the opcode class vector and the per-state
// control word with the function that decodes it.
package riscv_pkg;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OpcR   = 7'b0110011;
  localparam logic [6:0] OpcI   = 7'b0010011;
  localparam logic [6:0] OpcILd = 7'b0000011;
  localparam logic [6:0] OpcS   = 7'b0100011;
  localparam logic [6:0] OpcSb  = 7'b1100011;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExecR  = 4'd7,
    StExecI  = 4'd8,
    StAluWb  = 4'd9,
    StBranch = 4'd10,
    StTrap   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpBrCmp = 2'b01,
    AluOpFunct = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    AluSrcBRs2  = 2'b00,
    AluSrcBFour = 2'b01,
    AluSrcBImm  = 2'b10
  } alusrcb_e;

  // One-hot instruction class
  typedef struct packed {
    logic r;
    logic i;
    logic ld;
    logic st;
    logic br;
    logic illegal;
  } opclass_t;

  typedef struct packed {
    logic     mem_req;
    logic     memread;
    logic     memwrite;
    logic     iord;
    logic     irwrite;
    logic     pcwrite;
    logic     branch;
    logic     pcsource;
    logic     alusrca;
    alusrcb_e alusrcb;
    aluop_e   aluop;
    logic     memtoreg;
    logic     regwrite;
    logic     halted;
  } ctrl_t;

  // Moore decode of the control word. irwrite/pcwrite are raised for the
  // whole FETCH state here; the FSM qualifies them with mem_ready.
  function automatic ctrl_t state_ctrl(state_e st);
    ctrl_t c;
    c = '0;
    unique case (st)
      StFetch: begin
        c.mem_req = 1'b1;
        c.memread = 1'b1;
        c.alusrcb = AluSrcBFour;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      StDecode: c.alusrcb = AluSrcBImm;
      StMemAdr: begin
        c.alusrca = 1'b1;
        c.alusrcb = AluSrcBImm;
      end
      StMemRd: begin
        c.mem_req = 1'b1;
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      StMemWb: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      StMemWr: begin
        c.mem_req  = 1'b1;
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      StExecR: begin
        c.alusrca = 1'b1;
        c.aluop   = AluOpFunct;
      end
      StExecI: begin
        c.alusrca = 1'b1;
        c.alusrcb = AluSrcBImm;
      end
      StAluWb: c.regwrite = 1'b1;
      StBranch: begin
        c.alusrca  = 1'b1;
        c.aluop    = AluOpBrCmp;
        c.branch   = 1'b1;
        c.pcsource = 1'b1;
      end
      StTrap:  c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_opclass.sv
// Combinational opcode classifier.
// Ports:
//   opcode_i  - instr[6:0]
//   opclass_o - one-hot class {r, i, ld, st, br, illegal}
module mc_opclass
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output opclass_t   opclass_o
);

  always_comb begin
    opclass_o = '0;
    unique case (opcode_i)
      OpcR:    opclass_o.r  = 1'b1;
      OpcI:    opclass_o.i  = 1'b1;
      OpcILd:  opclass_o.ld = 1'b1;
      OpcS:    opclass_o.st = 1'b1;
      OpcSb:   opclass_o.br = 1'b1;
      default: opclass_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a shared-datapath multi-cycle RV32I core.
// Sequences fetch/decode/execute/memory/write-back through a per-state
// control word, handles the req/ready memory handshake with a wait
// timeout, and counts retired instructions.
// Ports:
//   clk_i, reset_i       - clock, asynchronous active-high reset
//   run_i                - start fetching (sampled in IDLE only)
//   opcode_i             - instr[6:0] from the instruction register
//   mem_ready_i          - memory completes the current request
//   mem_req_o .. regwrite_o - datapath / memory control strobes
//   halted_o             - FSM sits in TRAP
//   bus_err_o            - TRAP was reached through a memory timeout
//   retired_o            - retired-instruction count (wraps)
module multicycle_control
  import riscv_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                run_i,
  input  logic [6:0]          opcode_i,
  input  logic                mem_ready_i,
  output logic                mem_req_o,
  output logic                memread_o,
  output logic                memwrite_o,
  output logic                iord_o,
  output logic                irwrite_o,
  output logic                pcwrite_o,
  output logic                branch_o,
  output logic                pcsource_o,
  output logic                alusrca_o,
  output logic [1:0]          alusrcb_o,
  output logic [1:0]          aluop_o,
  output logic                memtoreg_o,
  output logic                regwrite_o,
  output logic                halted_o,
  output logic                bus_err_o,
  output logic [RETIRE_W-1:0] retired_o
);

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [7:0]            wait_q, wait_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;
  logic                  bus_err_q, bus_err_d;
  ctrl_t                 ctrl_q;
  opclass_t              opclass;
  logic                  retire;
  logic                  in_wait;
  logic                  timeout;

  mc_opclass u_opclass (
    .opcode_i  (opcode_i),
    .opclass_o (opclass)
  );

  always_comb begin
    state_d   = state_q;
    bus_err_d = bus_err_q;
    retire    = 1'b0;
    in_wait   = state_q inside {StFetch, StMemRd, StMemWr};
    // A ready response on the last allowed cycle still completes normally.
    timeout   = in_wait && !mem_ready_i && (wait_q == WaitLast);

    unique case (state_q)
      StIdle:   if (run_i) state_d = StFetch;
      StFetch:  if (mem_ready_i) state_d = StDecode;
      StDecode: begin
        unique case (1'b1)
          opclass.r:             state_d = StExecR;
          opclass.i:             state_d = StExecI;
          opclass.ld, opclass.st: state_d = StMemAdr;
          opclass.br:            state_d = StBranch;
          default:               state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        if (opclass.ld)      state_d = StMemRd;
        else if (opclass.st) state_d = StMemWr;
        else                 state_d = StTrap;
      end
      StMemRd:  if (mem_ready_i) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        if (mem_ready_i) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR, StExecI: state_d = StAluWb;
      StAluWb, StBranch: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase

    if (timeout) begin
      state_d   = StTrap;
      bus_err_d = 1'b1;
    end

    // Every entry into a wait state is a state change, so this clears it.
    if (state_d != state_q)             wait_d = '0;
    else if (in_wait && !mem_ready_i)   wait_d = wait_q + 8'd1;
    else                                wait_d = wait_q;

    retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, retire};
  end

  // Control word is registered from the next state so outputs come straight
  // off flops and drop to zero the moment reset is asserted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      retired_q <= '0;
      bus_err_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      bus_err_q <= bus_err_d;
      ctrl_q    <= state_ctrl(state_d);
    end
  end

  assign mem_req_o  = ctrl_q.mem_req;
  assign memread_o  = ctrl_q.memread;
  assign memwrite_o = ctrl_q.memwrite;
  assign iord_o     = ctrl_q.iord;
  assign irwrite_o  = ctrl_q.irwrite & mem_ready_i;
  assign pcwrite_o  = ctrl_q.pcwrite & mem_ready_i;
  assign branch_o   = ctrl_q.branch;
  assign pcsource_o = ctrl_q.pcsource;
  assign alusrca_o  = ctrl_q.alusrca;
  assign alusrcb_o  = ctrl_q.alusrcb;
  assign aluop_o    = ctrl_q.aluop;
  assign memtoreg_o = ctrl_q.memtoreg;
  assign regwrite_o = ctrl_q.regwrite;
  assign halted_o   = ctrl_q.halted;
  assign bus_err_o  = bus_err_q;
  assign retired_o  = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. The stimulus process expands each
// instruction into its expected cycle sequence and pushes one expected
// output record per cycle; the monitor pops and compares on the falling edge.
module tb_multicycle_control;

  localparam int unsigned RW = 4;
  localparam int unsigned TO = 16;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] S_OP  = 7'b0100011;
  localparam logic [6:0] B_OP  = 7'b1100011;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          mem_ready = 1'b0;
  logic [6:0]    opcode = '0;
  logic          mem_req, memread, memwrite, iord, irwrite, pcwrite, branch, pcsource;
  logic          alusrca, memtoreg, regwrite, halted, bus_err;
  logic [1:0]    alusrcb, aluop;
  logic [RW-1:0] retired;

  always #5 clk = ~clk;

  multicycle_control #(.RETIRE_W(RW), .TIMEOUT(TO)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .run_i       (run),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .mem_req_o   (mem_req),
    .memread_o   (memread),
    .memwrite_o  (memwrite),
    .iord_o      (iord),
    .irwrite_o   (irwrite),
    .pcwrite_o   (pcwrite),
    .branch_o    (branch),
    .pcsource_o  (pcsource),
    .alusrca_o   (alusrca),
    .alusrcb_o   (alusrcb),
    .aluop_o     (aluop),
    .memtoreg_o  (memtoreg),
    .regwrite_o  (regwrite),
    .halted_o    (halted),
    .bus_err_o   (bus_err),
    .retired_o   (retired)
  );

  typedef enum int {
    PIdle, PReset, PFetch, PDecode, PMemAdr, PMemRd, PMemWb, PMemWr,
    PExecR, PExecI, PAluWb, PBranch, PTrap
  } ph_e;

  typedef struct packed {
    logic          mem_req;
    logic          memread;
    logic          memwrite;
    logic          iord;
    logic          irwrite;
    logic          pcwrite;
    logic          branch;
    logic          pcsource;
    logic          alusrca;
    logic [1:0]    alusrcb;
    logic [1:0]    aluop;
    logic          memtoreg;
    logic          regwrite;
    logic          halted;
    logic          bus_err;
    logic [RW-1:0] retired;
  } obs_t;

  // One planned cycle: phase, mem_ready to drive, set bus_err before it,
  // retire after it.
  typedef struct {
    ph_e  p;
    logic rdy;
    logic err;
    logic ret;
  } cyc_t;

  obs_t          exp_q[$];
  string         tag_q[$];
  cyc_t          plan[$];
  int            checks = 0;
  int            failures = 0;
  logic [RW-1:0] retired_m = '0;
  logic          bus_err_m = 1'b0;

  function automatic obs_t expect_obs(ph_e p, logic rdy);
    obs_t o;
    o = '0;
    case (p)
      PFetch: begin
        o.mem_req = 1; o.memread = 1; o.alusrcb = 2'b01;
        o.irwrite = rdy; o.pcwrite = rdy;
      end
      PDecode: o.alusrcb = 2'b10;
      PMemAdr: begin o.alusrca = 1; o.alusrcb = 2'b10; end
      PMemRd:  begin o.mem_req = 1; o.memread = 1; o.iord = 1; end
      PMemWb:  begin o.regwrite = 1; o.memtoreg = 1; end
      PMemWr:  begin o.mem_req = 1; o.memwrite = 1; o.iord = 1; end
      PExecR:  begin o.alusrca = 1; o.aluop = 2'b10; end
      PExecI:  begin o.alusrca = 1; o.alusrcb = 2'b10; end
      PAluWb:  o.regwrite = 1;
      PBranch: begin o.alusrca = 1; o.aluop = 2'b01; o.branch = 1; o.pcsource = 1; end
      PTrap:   o.halted = 1;
      default: o = '0;
    endcase
    o.bus_err = bus_err_m;
    o.retired = retired_m;
    return o;
  endfunction

  task automatic step(input ph_e p, input logic rdy, input logic [6:0] opc,
                      input logic run_v, input logic rst_v);
    reset = rst_v; run = run_v; mem_ready = rdy; opcode = opc;
    exp_q.push_back(expect_obs(p, rdy));
    tag_q.push_back(p.name());
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    retired_m = '0;
    bus_err_m = 1'b0;
    repeat (n) step(PReset, 1'($urandom), 7'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic go_idle(input int n);
    repeat (n) step(PIdle, 1'($urandom), 7'($urandom), 1'b0, 1'b0);
    step(PIdle, 1'($urandom), 7'($urandom), 1'b1, 1'b0);
  endtask

  task automatic hold_trap(input int n);
    repeat (n) step(PTrap, 1'($urandom), 7'($urandom), 1'($urandom), 1'b0);
  endtask

  function automatic void push(ph_e p, logic rdy, logic err, logic ret);
    cyc_t c;
    c.p = p; c.rdy = rdy; c.err = err; c.ret = ret;
    plan.push_back(c);
  endfunction

  // Returns 1 when the wait state times out into TRAP.
  function automatic bit add_wait(ph_e p, int waits);
    if (waits >= int'(TO)) begin
      for (int i = 0; i < int'(TO); i++) push(p, 1'b0, 1'b0, 1'b0);
      push(PTrap, 1'($urandom), 1'b1, 1'b0);
      return 1'b1;
    end
    for (int i = 0; i < waits; i++) push(p, 1'b0, 1'b0, 1'b0);
    push(p, 1'b1, 1'b0, p == PMemWr);
    return 1'b0;
  endfunction

  // Expand one instruction from FETCH; abort_at >= 0 resets at that cycle.
  task automatic run_instr(input logic [6:0] opc, input int wf, input int wm,
                           input int abort_at);
    plan.delete();
    if (!add_wait(PFetch, wf)) begin
      push(PDecode, 1'($urandom), 1'b0, 1'b0);
      case (opc)
        R_OP: begin
          push(PExecR, 1'($urandom), 1'b0, 1'b0);
          push(PAluWb, 1'($urandom), 1'b0, 1'b1);
        end
        I_OP: begin
          push(PExecI, 1'($urandom), 1'b0, 1'b0);
          push(PAluWb, 1'($urandom), 1'b0, 1'b1);
        end
        LD_OP: begin
          push(PMemAdr, 1'($urandom), 1'b0, 1'b0);
          if (!add_wait(PMemRd, wm)) push(PMemWb, 1'($urandom), 1'b0, 1'b1);
        end
        S_OP: begin
          push(PMemAdr, 1'($urandom), 1'b0, 1'b0);
          void'(add_wait(PMemWr, wm));
        end
        B_OP:    push(PBranch, 1'($urandom), 1'b0, 1'b1);
        default: push(PTrap, 1'($urandom), 1'b0, 1'b0);
      endcase
    end
    foreach (plan[k]) begin
      if (k == abort_at) begin
        do_reset(2);
        return;
      end
      if (plan[k].err) bus_err_m = 1'b1;
      step(plan[k].p, plan[k].rdy,
           (plan[k].p == PFetch || plan[k].p == PTrap) ? 7'($urandom) : opc,
           1'($urandom), 1'b0);
      if (plan[k].ret) retired_m = retired_m + 1'b1;
    end
  endtask

  function automatic int rnd_wait();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 0;
    if (r < 9) return int'($urandom_range(1, 3));
    return int'(TO) - 1;
  endfunction

  function automatic logic [6:0] rnd_legal();
    case ($urandom_range(0, 4))
      0: return R_OP;
      1: return I_OP;
      2: return LD_OP;
      3: return S_OP;
      default: return B_OP;
    endcase
  endfunction

  function automatic logic [6:0] rnd_illegal();
    logic [6:0] o;
    o = 7'b1101111;
    if ($urandom_range(0, 1) == 1) begin
      do o = 7'($urandom);
      while (o == R_OP || o == I_OP || o == LD_OP || o == S_OP || o == B_OP);
    end
    return o;
  endfunction

  always @(negedge clk) begin
    obs_t  e;
    obs_t  a;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a.mem_req = mem_req;   a.memread = memread;   a.memwrite = memwrite;
      a.iord = iord;         a.irwrite = irwrite;   a.pcwrite = pcwrite;
      a.branch = branch;     a.pcsource = pcsource; a.alusrca = alusrca;
      a.alusrcb = alusrcb;   a.aluop = aluop;       a.memtoreg = memtoreg;
      a.regwrite = regwrite; a.halted = halted;     a.bus_err = bus_err;
      a.retired = retired;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s @%0t: got=%h expected=%h", t, $time, a, e);
      end
    end
  end

  initial begin
    @(posedge clk); #1;
    do_reset(2);
    go_idle(2);

    // Zero-wait R, load with three MEMRD waits, store, branch
    run_instr(R_OP, 0, 0, -1);
    run_instr(LD_OP, 0, 3, -1);
    run_instr(S_OP, 0, 0, -1);
    run_instr(B_OP, 0, 0, -1);

    for (int n = 0; n < 30; n++) run_instr(rnd_legal(), rnd_wait(), rnd_wait(), -1);

    // Ready on the last allowed FETCH cycle, then a FETCH timeout
    run_instr(I_OP, int'(TO) - 1, 0, -1);
    run_instr(R_OP, int'(TO), 0, -1);
    hold_trap(5);
    do_reset(1);
    go_idle(1);

    // Unsupported opcode traps without bus error
    run_instr(R_OP, 0, 0, -1);
    run_instr(rnd_illegal(), 0, 0, -1);
    hold_trap(4);
    do_reset(1);
    go_idle(0);

    // Reset in the middle of a waiting MEMWR
    run_instr(R_OP, 0, 0, -1);
    run_instr(S_OP, 0, 2, 4);
    go_idle(1);

    // Enough retirements to wrap the 4-bit counter
    for (int n = 0; n < 22; n++) run_instr(rnd_legal(), rnd_wait(), rnd_wait(), -1);

    // MEMWR ready on the last allowed cycle, then a MEMRD timeout
    run_instr(S_OP, 0, int'(TO) - 1, -1);
    run_instr(LD_OP, 1, int'(TO), -1);
    hold_trap(3);

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
